// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the multi-cycle LEGv8 sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        R_TYPE,
        LOAD,
        STORE,
        CBZ,
        BRANCH,
        ILLEGAL
    } op_class_t;

    localparam logic [10:0] OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] OP_STUR    = 11'b11111000000;
    localparam logic [10:0] OP_ADD     = 11'b10001011000;
    localparam logic [10:0] OP_SUB     = 11'b11001011000;
    localparam logic [10:0] OP_AND     = 11'b10001010000;
    localparam logic [10:0] OP_ORR     = 11'b10101010000;
    // CBZ and B carry register/offset bits in the low opcode bits, so only a prefix is decoded
    localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  OP_B_PFX   = 6'b000101;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational map from instruction[31:21] to an instruction class.
module opcode_classifier
    import seq_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   op_class
);

    always_comb begin
        op_class = ILLEGAL;
        if (opcode == OP_LDUR) begin
            op_class = LOAD;
        end else if (opcode == OP_STUR) begin
            op_class = STORE;
        end else if (opcode == OP_ADD || opcode == OP_SUB ||
                     opcode == OP_AND || opcode == OP_ORR) begin
            op_class = R_TYPE;
        end else if (opcode[10:3] == OP_CBZ_PFX) begin
            op_class = CBZ;
        end else if (opcode[10:5] == OP_B_PFX) begin
            op_class = BRANCH;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM with memory handshakes.
// Define PERF_CNT_EN to add the retired_count / stall_count performance counters.
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | imem_req held until imem_ack; IR and PC+4 written on the ack
// DECODE  | register-file read, opcode legality check
// EXECUTE | ALU cycle; branch target written here
// MEM     | dmem_read / dmem_write held until dmem_ack
// WB      | register-file write
// HALT    | illegal opcode or bus timeout; left only by reset
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [10:0] opcode,
    input  logic        alu_zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        rf_read_en,
    output logic        rf_write_en,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        bus_error,
    output logic [2:0]  state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] retired_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [4:0] WAIT_LAST = 5'(ACK_TIMEOUT - 1);

    state_t    cur, nxt;
    op_class_t op_class;
    logic [4:0] wait_cnt, wait_nxt;
    logic       illegal_set, bus_err_set;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= IDLE;
            wait_cnt  <= 5'd0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            cur      <= nxt;
            wait_cnt <= wait_nxt;
            if (illegal_set) illegal   <= 1'b1;
            if (bus_err_set) bus_error <= 1'b1;
        end
    end

    always_comb begin
        nxt         = cur;
        wait_nxt    = wait_cnt;
        imem_req    = 1'b0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        rf_read_en  = 1'b0;
        rf_write_en = 1'b0;
        mem_to_reg  = 1'b0;
        illegal_set = 1'b0;
        bus_err_set = 1'b0;

        case (cur)
            IDLE: begin
                if (run) begin
                    nxt      = FETCH;
                    wait_nxt = 5'd0;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    bus_err_set = 1'b1;
                    nxt         = HALT;
                end else begin
                    wait_nxt = wait_cnt + 5'd1;
                end
            end
            DECODE: begin
                rf_read_en = 1'b1;
                if (op_class == ILLEGAL) begin
                    illegal_set = 1'b1;
                    nxt         = HALT;
                end else begin
                    nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                case (op_class)
                    R_TYPE: nxt = WB;
                    LOAD, STORE: begin
                        nxt      = MEM;
                        wait_nxt = 5'd0;
                    end
                    BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        nxt      = run ? FETCH : IDLE;
                        wait_nxt = 5'd0;
                    end
                    CBZ: begin
                        pc_write = alu_zero;
                        pc_src   = alu_zero;
                        nxt      = run ? FETCH : IDLE;
                        wait_nxt = 5'd0;
                    end
                    default: begin
                        illegal_set = 1'b1;
                        nxt         = HALT;
                    end
                endcase
            end
            MEM: begin
                dmem_read  = (op_class == LOAD);
                dmem_write = (op_class != LOAD);
                if (dmem_ack) begin
                    if (op_class == LOAD) begin
                        nxt = WB;
                    end else begin
                        nxt      = run ? FETCH : IDLE;
                        wait_nxt = 5'd0;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    bus_err_set = 1'b1;
                    nxt         = HALT;
                end else begin
                    wait_nxt = wait_cnt + 5'd1;
                end
            end
            WB: begin
                rf_write_en = 1'b1;
                mem_to_reg  = (op_class == LOAD);
                nxt         = run ? FETCH : IDLE;
                wait_nxt    = 5'd0;
            end
            default: nxt = cur;
        endcase

        // Reset wins over the state decode so no write strobe escapes an abort.
        if (reset) begin
            imem_req    = 1'b0;
            dmem_read   = 1'b0;
            dmem_write  = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 1'b0;
            rf_read_en  = 1'b0;
            rf_write_en = 1'b0;
            mem_to_reg  = 1'b0;
        end
    end

    assign state = cur;

`ifdef PERF_CNT_EN
    logic instr_done, stall_cycle;

    assign stall_cycle = (imem_req && !imem_ack) || ((dmem_read || dmem_write) && !dmem_ack);
    assign instr_done  = (cur == WB) ||
                         (cur == EXECUTE && (op_class == BRANCH || op_class == CBZ)) ||
                         (cur == MEM && dmem_ack && op_class != LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= 32'd0;
            stall_count   <= 32'd0;
        end else begin
            if (instr_done)  retired_count <= retired_count + 32'd1;
            if (stall_cycle) stall_count   <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control FSM that sequences the LEGv8 fetch/decode/execute/memory/writeback datapath, one instruction at a time, around the existing `iDecode` stage, register file and ALU. It owns the instruction-memory and data-memory request handshakes and issues one-cycle enables to the PC, the instruction register, the register-file ports and memory. It sits between instruction memory and `iDecode`. Its `opcode` input is taken from `iDecode`.

## Interface
Parameters:
- `ACK_TIMEOUT`, 16: maximum cycles to wait for `imem_ack`/`dmem_ack` before flagging `bus_error`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level; permits leaving IDLE and continuing after each instruction.
- `opcode`  in  11  instruction[31:21] from `iDecode`.
- `alu_zero`  in  1  ALU zero flag, valid in EXECUTE.
- `imem_ack`  in  1  instruction memory has data this cycle.
- `dmem_ack`  in  1  data memory has completed its access this cycle.
- `imem_req`  out  1  instruction fetch request.
- `dmem_read` / `dmem_write`  out  1 each  data memory request.
- `ir_write`  out  1  latch instruction register and old PC.
- `pc_write`  out  1  PC update strobe.
- `pc_src`  out  1  0 = PC+4, 1 = branch target.
- `rf_read_en`  out  1  register-file read strobe (replaces `read_clk`).
- `rf_write_en`  out  1  register-file write strobe (replaces `write_clk`).
- `mem_to_reg`  out  1  writeback mux select.
- `illegal`  out  1  sticky; unknown opcode decoded.
- `bus_error`  out  1  sticky; handshake timeout.
- `state`  out  3  current FSM state, for debug.

## Operation
- Opcode classes: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100xxx, B 000101xxxxx. Any other value is illegal.
- States are IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- IDLE: all strobes 0. Goes to FETCH when `run`=1.
- FETCH: `imem_req`=1 until `imem_ack` is sampled high. On the ack cycle, `ir_write`=1 and `pc_write`=1 with `pc_src`=0, then the FSM goes to DECODE.
- DECODE: `rf_read_en`=1 for one cycle. An illegal opcode sets `illegal` and goes to HALT. Otherwise the FSM goes to EXECUTE.
- EXECUTE, one cycle:
  - R-type goes to WB.
  - LDUR/STUR go to MEM.
  - B asserts `pc_write`=1 and `pc_src`=1, then ends the instruction.
  - CBZ asserts `pc_write` and `pc_src`=1 only if `alu_zero`=1, then ends the instruction.
- MEM: `dmem_read` (LDUR) or `dmem_write` (STUR) is held until `dmem_ack`. After the ack, LDUR goes to WB and STUR ends the instruction.
- WB: `rf_write_en`=1 for one cycle. `mem_to_reg`=1 for LDUR, 0 for R-type. Then the instruction ends.
- End of instruction: go to FETCH if `run`=1, else IDLE.
- Timeout: a 5-bit wait counter clears on entering FETCH or MEM and increments each cycle without an ack. If it reaches `ACK_TIMEOUT` with no ack, the FSM drops the request, sets `bus_error` and goes to HALT.
- HALT: all strobes 0. It is left only by `reset`.

## Timing
- Reset: state=IDLE. Every output is 0, including the sticky flags and the wait counter.
- `reset` mid-handshake drops `imem_req`/`dmem_*` in the next cycle. No `pc_write`, `ir_write` or `rf_write_en` is issued.
- All outputs are decoded from registered state plus same-cycle `imem_ack`/`dmem_ack`/`alu_zero` (Mealy on the acks). There are no registered strobes.
- Minimum latency with zero-wait ack, in cycles: R-type 4, LDUR 5, STUR 4, CBZ/B 3.
- An ack arriving in the same cycle as the request completes the handshake that cycle.
- An ack outside FETCH/MEM is ignored.
- A `run` deassertion mid-instruction takes effect only at end of instruction.
- `opcode` must be stable from DECODE through the end of the instruction. The IR does not change until the next `ir_write`.
- Fetch and the branch PC write never coincide: PC+4 is written in FETCH, the branch target in EXECUTE.

## Configuration
- `PERF_CNT_EN` defined: adds two outputs, `retired_count` (out, 32) and `stall_count` (out, 32). Both reset to 0 and wrap at 2^32.
  - `retired_count` increments once per completed instruction.
  - `stall_count` increments on every FETCH or MEM cycle with the request high and ack low.
- `PERF_CNT_EN` undefined: neither port nor any counter logic exists. All other behaviour is identical.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum;
  - the opcode class enum {R_TYPE, LOAD, STORE, CBZ, BRANCH, ILLEGAL};
  - the opcode constants above.
- One sub-module, `opcode_classifier`: combinational mapping from 11-bit `opcode` to class. It is shared with future decode work.

## Test plan
- ADD (10001011000), acks in the same cycle: state sequence 1,2,3,5 then 1. One `rf_write_en` pulse with `mem_to_reg`=0. 4 cycles per instruction.
- LDUR with `dmem_ack` delayed 3 cycles: `dmem_read` is high for 4 cycles, then WB with `mem_to_reg`=1 and a single `rf_write_en`.
- CBZ: with `alu_zero`=1 → `pc_write`=1, `pc_src`=1 in EXECUTE. With `alu_zero`=0 → no EXECUTE `pc_write`. Next state is FETCH in both cases.
- Opcode 0 in DECODE → `illegal`=1 and state=6. `run` toggling has no effect. `reset` returns all outputs to 0.
- `imem_ack` withheld for `ACK_TIMEOUT`=16 cycles → `bus_error`=1, `imem_req`=0, HALT.
- `reset` asserted during a MEM wait → next cycle IDLE and all strobes 0. With `PERF_CNT_EN`, `retired_count` matches the number of completed instructions and the count is 0 after reset.
